// File: rtl/random_engine_reader_if.sv
// Request / response bundle between a host and the random engine reader.
// The host side drives requests and accepts samples; the reader side answers.
interface random_engine_reader_if #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
);
    logic               req_val;
    logic               req_rdy;
    logic [COUNT_W-1:0] req_count;
    logic               resp_val;
    logic               resp_rdy;
    logic [WIDTH-1:0]   resp_data;
    logic               resp_last;

    modport master (
        output req_val,
        output req_count,
        output resp_rdy,
        input  req_rdy,
        input  resp_val,
        input  resp_data,
        input  resp_last
    );

    modport slave (
        input  req_val,
        input  req_count,
        input  resp_rdy,
        output req_rdy,
        output resp_val,
        output resp_data,
        output resp_last
    );
endinterface

// File: rtl/random_engine_reader.sv
// Host-side initiator for the random engine: starts it, collects a counted
// number of LFSR samples through a one-entry buffer, then stops it.
module random_engine_reader #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    random_engine_reader_if.slave  bus,
    output logic                   eng_start,
    output logic                   eng_stop,
    input  logic                   eng_active,
    input  logic [WIDTH-1:0]       eng_data,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        COLLECT,
        STOP,
        DRAIN
    } state_t;

    state_t             state;
    logic [COUNT_W-1:0] remaining;
    logic               buf_free;
    logic               resp_hs;
    logic               cap;
    logic               last_one;

    assign buf_free = !bus.resp_val || bus.resp_rdy;
    assign resp_hs  = bus.resp_val && bus.resp_rdy;
    assign last_one = (remaining == COUNT_W'(1));
    assign cap      = (state == COLLECT) && eng_active &&
                      (remaining != '0) && buf_free;

    // Gated by rst so the output is low while reset is held.
    assign bus.req_rdy = rst && (state == IDLE) && !eng_active;

    // Control FSM with registered engine pulses, busy and response buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            remaining     <= '0;
            eng_start     <= 1'b0;
            eng_stop      <= 1'b0;
            busy          <= 1'b0;
            bus.resp_val  <= 1'b0;
            bus.resp_data <= '0;
            bus.resp_last <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            eng_stop  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (eng_active) begin
                        state    <= STOP;
                        eng_stop <= 1'b1;
                        busy     <= 1'b1;
                    end else if (bus.req_val && bus.req_count != '0) begin
                        remaining <= bus.req_count;
                        state     <= START;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    state <= COLLECT;
                end
                COLLECT: begin
                    if (cap && last_one) begin
                        state    <= STOP;
                        eng_stop <= 1'b1;
                    end
                end
                STOP: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!eng_active && buf_free) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (cap) begin
                bus.resp_data <= eng_data;
                bus.resp_val  <= 1'b1;
                bus.resp_last <= last_one;
                remaining     <= remaining - COUNT_W'(1);
            end else if (resp_hs) begin
                bus.resp_val <= 1'b0;
            end
        end
    end

endmodule

// File: doc/random_engine_reader.md
# random_engine_reader

- Host-side initiator for the random engine's start/stop/active interface; the consumer end of that engine.
- On a request for N samples it pulses `start` and waits for `active`. It captures N values of the engine's LFSR output through a one-entry valid/ready response buffer, then pulses `stop` and waits for the engine to go idle.
- It sits between a host/test harness and the random engine. It turns a free-running engine into a counted, flow-controlled sample stream.

## Interface

Parameters:
- WIDTH, 32, width of an engine sample and of `resp_data`
- COUNT_W, 8, width of the requested sample count

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_count  in  COUNT_W  number of samples requested (0 allowed)
- eng_start  out  1  one-cycle pulse to engine `start`
- eng_stop  out  1  one-cycle pulse to engine `stop`
- eng_active  in  1  engine `active`; LFSR advances every cycle while high
- eng_data  in  WIDTH  current engine LFSR value
- resp_val  out  1  sample valid
- resp_rdy  in  1  sample accepted by consumer
- resp_data  out  WIDTH  captured sample
- resp_last  out  1  marks the final sample of a request
- busy  out  1  high whenever the FSM is not in IDLE

## Operation

- **Reset:** FSM goes to IDLE and the remaining counter to 0. All outputs are 0 while reset is asserted (`req_rdy`, `eng_start`, `eng_stop`, `resp_val`, `resp_data`, `resp_last`, `busy`).
- **States:** IDLE, START, COLLECT, STOP, DRAIN. `busy` = state != IDLE.
- **IDLE:**
  - `req_rdy` = (`eng_active` == 0).
  - On `req_val` && `req_rdy` with `req_count` != 0: latch remaining = `req_count`, go to START.
  - On a handshake with `req_count` == 0: request is consumed, no response, stay in IDLE.
  - If `eng_active` == 1 in IDLE (stale engine after reset): go to STOP to shut it down. No request is accepted.
- **START:** `eng_start` = 1 for exactly this cycle, then COLLECT.
- **COLLECT:**
  - cap = `eng_active` && remaining != 0 && (!`resp_val` || `resp_rdy`).
  - On cap: `resp_data` <= `eng_data`; `resp_val` <= 1; `resp_last` <= (remaining == 1); remaining decrements.
  - On cap with remaining == 1: go to STOP.
  - Engine values produced while the buffer is full and not draining are discarded. The engine keeps free-running and is never stalled.
- **STOP:** `eng_stop` = 1 for exactly this cycle, then DRAIN.
- **DRAIN:** go to IDLE when `eng_active` == 0 and (!`resp_val` || `resp_rdy`).
- **Response buffer, all states:**
  - `resp_val` clears on a handshake when no capture occurs in the same cycle.
  - `resp_data` and `resp_last` hold while `resp_val` && !`resp_rdy`.
- **Width rules:** remaining is COUNT_W bits with no wrap; decrement only occurs when remaining != 0. Maximum request is 2^COUNT_W − 1 samples.

## Timing

- Engine behaviour relied on: `active` rises 1 cycle after `start` is sampled and falls 1 cycle after `stop` is sampled.
- Request handshake at cycle 0 with N > 0:
  - START in cycle 1 (`eng_start` high).
  - `eng_active` high from cycle 2.
  - First capture at the end of cycle 2, so `resp_val` is first high in cycle 3.
- With `resp_rdy` held at 1:
  - N samples appear in cycles 3..N+2, equal to `eng_data` of cycles 2..N+1 (consecutive LFSR states).
  - `resp_last` is high in cycle N+2.
  - `eng_stop` is high in cycle N+2; `eng_active` falls in cycle N+3.
  - DRAIN in cycle N+3, IDLE in cycle N+4, with `req_rdy` high in cycle N+4.
- **Capture and handshake in the same cycle:** the new sample replaces the old one and `resp_val` stays 1.
- **Backpressure:** each stalled cycle delays one capture. The captured sample is whatever the engine holds in the cycle the buffer frees up, so samples are not consecutive LFSR states.
- **Reset mid-operation:**
  - Outputs clear immediately (asynchronously).
  - A pending sample is lost.
  - After release, a still-active engine is stopped via IDLE→STOP→DRAIN before `req_rdy` rises.

## Test plan

- **Reset:** assert rst=0 mid-COLLECT with `resp_val`=1 -> all outputs 0 immediately. After release with `eng_active`=1 -> `eng_stop` pulses once; `req_rdy` rises only after `eng_active` falls.
- **N=4, `resp_rdy`=1, engine model with seed 0x1:**
  - `eng_start` in cycle 1.
  - 4 samples in cycles 3..6 equal to the model's LFSR states of cycles 2..5.
  - `resp_last` only in cycle 6; `eng_stop` in cycle 6; `req_rdy` high in cycle 8.
- **N=3, `resp_rdy` low for cycles 3..5:** first sample held stable for 3 cycles, exactly 3 samples total, `resp_last` on the third only, `eng_stop` issued once.
- **`req_count`=0:** request accepted in 1 cycle; no `eng_start`, no `resp_val`; `busy` stays 0.
- **Maximum count 255 with random `resp_rdy`:** exactly 255 handshakes; `resp_last` on the 255th only; no extra capture after remaining reaches 0.
- **Back-to-back requests N=2 then N=1:** second request accepted only after DRAIN completes; second stream is 1 sample with `resp_last`=1.
